mem_access_unit: RTL and testbench

Load/store initiator that sits between the pipeline's memory stage and the word-indexed data memory. It accepts one load or store request at a time through a valid/ready handshake and converts byte addresses to word indices. It performs sub-word stores as read-modify-write sequences, sign- or zero-extends sub-word loads, and returns a single-cycle response pulse. It drives the memory's `MemRead`, `MemWrite`, `ALUOut` and `reg2data` inputs and consumes `memout`.

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator for the word-indexed data memory.
//               Sub-word accesses (RMW stores, extended loads) are built only
//               when MAU_SUBWORD_EN is defined; otherwise only word accesses
//               are legal.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int MEM_WORDS = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] ALUOut,
  output logic [31:0] reg2data,
  input  logic [31:0] memout
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RD      = 2'd1;
  localparam logic [1:0] c_WR      = 2'd2;
  localparam logic [1:0] c_RESP    = 2'd3;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [31:0] r_aluout;
  logic [31:0] r_reg2data;
  logic [31:0] r_rdata;
  logic        r_write;
  logic        r_err;
  logic [31:0] w_word_idx;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_size_err;
  logic        w_req_err;
  logic        w_accept;

  assign w_word_idx = {2'b00, req_addr[31:2]};
  assign w_accept   = req_valid && (r_state == c_IDLE);
  assign w_req_err  = w_size_err || (w_word_idx >= 32'(MEM_WORDS));

`ifdef MAU_SUBWORD_EN
  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;

  logic [1:0]  r_addr_lo;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size_err = (req_size == 2'b11) ||
                      ((req_size == c_SZ_HALF) && req_addr[0]) ||
                      ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_lo <= 2'b00;
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
    end else if (w_accept) begin
      r_addr_lo <= req_addr[1:0];
      r_size    <= req_size;
      r_signed  <= req_signed;
    end
  end

  // Lane extraction for loads and lane replacement for RMW stores;
  // r_reg2data still holds the right-aligned store data during RD.
  always_comb begin
    w_byte      = memout[{r_addr_lo, 3'b000} +: 8];
    w_half      = r_addr_lo[1] ? memout[31:16] : memout[15:0];
    w_load_data = memout;
    w_merged    = memout;
    case (r_size)
      c_SZ_BYTE: begin
        w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
        w_merged[{r_addr_lo, 3'b000} +: 8] = r_reg2data[7:0];
      end
      c_SZ_HALF: begin
        w_load_data = {{16{r_signed & w_half[15]}}, w_half};
        w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_reg2data[15:0];
      end
      default: w_merged = r_reg2data;
    endcase
  end
`else
  logic w_unused;

  assign w_unused    = req_signed;
  assign w_size_err  = (req_size != c_SZ_WORD) || (req_addr[1:0] != 2'b00);
  assign w_load_data = memout;
  assign w_merged    = r_reg2data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                               w_next = c_RESP;
          else if (req_write && req_size == c_SZ_WORD) w_next = c_WR;
          else                                         w_next = c_RD;
        end
      end
      c_RD:    w_next = r_write ? c_WR : c_RESP;
      c_WR:    w_next = c_RESP;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aluout   <= '0;
      r_reg2data <= '0;
      r_rdata    <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_aluout   <= w_word_idx;
      r_reg2data <= req_wdata;
      r_rdata    <= '0;
      r_write    <= req_write;
      r_err      <= w_req_err;
    end else if (r_state == c_RD) begin
      if (r_write) r_reg2data <= w_merged;
      else         r_rdata    <= w_load_data;
    end
  end

  // Every output, including the memory strobes, is forced low while in reset.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUOut     = '0;
    reg2data   = '0;
    if (rst_n) begin
      ALUOut   = r_aluout;
      reg2data = r_reg2data;
      case (r_state)
        c_IDLE: req_ready = 1'b1;
        c_RD:   MemRead   = 1'b1;
        c_WR:   MemWrite  = 1'b1;
        default: begin
          resp_valid = 1'b1;
          resp_rdata = r_rdata;
          resp_err   = r_err;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed table-driven bench for mem_access_unit with a
//               behavioural data memory; expectations follow MAU_SUBWORD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef MAU_SUBWORD_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALUOut;
  logic [31:0] reg2data;
  logic [31:0] memout;

  logic [31:0] mem [0:255];
  logic        mem_loaded = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_WORDS(200)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUOut(ALUOut), .reg2data(reg2data), .memout(memout)
  );

  always #5 clk = ~clk;

  assign memout = mem[ALUOut[7:0]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8]     <= 32'hF0F0F0F0;
      mem[10]    <= 32'h00000005;
      mem[199]   <= 32'hCAFE0001;
      mem_loaded <= 1'b1;
    end else if (MemWrite) begin
      mem[ALUOut[7:0]] <= reg2data;
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_w2;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input int lat, input int nrd,
                              input int nwr, input logic [31:0] w2);
    vec_t v;
    v.wr = wr; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = 1'b0; v.exp_lat = lat;
    v.exp_rd = nrd; v.exp_wr = nwr; v.exp_w2 = w2;
    return v;
  endfunction

  function automatic vec_t mke(input logic wr, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd);
    vec_t v;
    v = mk(wr, sz, sg, a, wd, 32'h0, 1, 0, 0, 32'h0);
    v.exp_err = 1'b1;
    return v;
  endfunction

  function automatic vec_t pick(input vec_t a, input vec_t b);
    if (SW) return a;
    return b;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int nrd = 0, nwr = 0, both = 0, rdy = 0, lat = 0;
    logic [31:0] rdata = 32'hDEADBEEF, w2 = 32'h0, idx = 32'hFFFFFFFF;
    logic err = 1'bx;
    bit got = 0;
    @(negedge clk);
    req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    #1 chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (MemRead || MemWrite) idx = ALUOut;
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; w2 = reg2data; end
      if (MemRead && MemWrite) both++;
      if (req_ready) rdy++;
      if (resp_valid) begin got = 1; lat = k; rdata = resp_rdata; err = resp_err; end
    end
    chk({tag, "_lat"},   lat,   v.exp_lat);
    chk({tag, "_err"},   {31'h0, err}, {31'h0, v.exp_err});
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    chk({tag, "_nrd"},   nrd,   v.exp_rd);
    chk({tag, "_nwr"},   nwr,   v.exp_wr);
    chk({tag, "_both"},  both,  0);
    chk({tag, "_busy"},  rdy,   0);
    if (v.exp_rd + v.exp_wr > 0) chk({tag, "_idx"}, idx, {2'b00, v.addr[31:2]});
    if (v.exp_wr > 0) chk({tag, "_w2"}, w2, v.exp_w2);
    @(negedge clk);
    chk({tag, "_pulse"}, {30'h0, resp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] exp8;
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    vecs[0]  = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hF0F0F0F0, 2, 1, 0, 32'h0);
    vecs[1]  = pick(mk(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'hFFFFFFF0, 2, 1, 0, 32'h0),
                    mke(1'b0, 2'b00, 1'b1, 32'h21, 32'h0));
    vecs[2]  = pick(mk(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h000000F0, 2, 1, 0, 32'h0),
                    mke(1'b0, 2'b00, 1'b0, 32'h21, 32'h0));
    vecs[3]  = pick(mk(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFFF0F0, 2, 1, 0, 32'h0),
                    mke(1'b0, 2'b01, 1'b1, 32'h22, 32'h0));
    vecs[4]  = pick(mk(1'b1, 2'b00, 1'b0, 32'h22, 32'hAB, 32'h0, 3, 1, 1, 32'hF0ABF0F0),
                    mke(1'b1, 2'b00, 1'b0, 32'h22, 32'hAB));
    vecs[5]  = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, SW ? 32'hF0ABF0F0 : 32'hF0F0F0F0, 2, 1, 0, 32'h0);
    vecs[6]  = mke(1'b0, 2'b01, 1'b0, 32'h29, 32'h0);
    vecs[7]  = mke(1'b0, 2'b10, 1'b0, 32'h320, 32'h0);
    vecs[8]  = mke(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    vecs[9]  = mk(1'b1, 2'b10, 1'b0, 32'h24, 32'h11223344, 32'h0, 2, 0, 1, 32'h11223344);
    vecs[10] = mk(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h11223344, 2, 1, 0, 32'h0);
    vecs[11] = pick(mk(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h000000F0, 2, 1, 0, 32'h0),
                    mke(1'b0, 2'b00, 1'b0, 32'h20, 32'h0));
    vecs[12] = mk(1'b0, 2'b10, 1'b1, 32'h31C, 32'h0, 32'hCAFE0001, 2, 1, 0, 32'h0);
    vecs[13] = pick(mk(1'b1, 2'b01, 1'b0, 32'h26, 32'h1234BEEF, 32'h0, 3, 1, 1, 32'hBEEF3344),
                    mke(1'b1, 2'b01, 1'b0, 32'h26, 32'h1234BEEF));
    vecs[14] = pick(mk(1'b0, 2'b01, 1'b0, 32'h26, 32'h0, 32'h0000BEEF, 2, 1, 0, 32'h0),
                    mke(1'b0, 2'b01, 1'b0, 32'h26, 32'h0));
    vecs[15] = mke(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);

    // Reset: every output held low, then ready in the first released cycle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {27'h0, req_ready, resp_valid, resp_err, MemRead, MemWrite}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    #1 chk("rst_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset lands on the WR cycle of a word store: nothing may be committed.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h28;
    req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rstwr_memwrite", {31'h0, MemWrite}, 32'h0);
    chk("rstwr_outs", ALUOut | reg2data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rstwr_ready", {31'h0, req_ready}, 32'h1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || MemWrite) seen++;
    end
    chk("rstwr_quiet", seen, 0);
    chk("rstwr_mem10", mem[10], 32'h5);
    run_vec(mk(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 32'h5, 2, 1, 0, 32'h0), "rstwr_ld");

    // Back-to-back loads with req_valid held: second acceptance in cycle 3.
    exp8 = SW ? 32'hF0ABF0F0 : 32'hF0F0F0F0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_valid = 1'b1;
    #1 chk("b2b_ready0", {31'h0, req_ready}, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", k), {31'h0, req_ready}, (k == 3) ? 32'h1 : 32'h0);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 8 && seen == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = k;
        chk("b2b_rdata", resp_rdata, exp8);
      end
    end
    chk("b2b_lat", seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
